potential_sequencer: RTL

//  Initiator side of the potential-adder interface. Holds membrane potential and pending input weight
//  for N_NEURONS neurons and, per timestep, walks the neurons in index order. For each neuron it drives

---
 rtl/potential_sequencer_if.sv | 21 ++
 rtl/potential_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/potential_sequencer_if.sv
// Operand/result channel between the potential sequencer (master) and the potential adder (slave).
interface potential_sequencer_if;
    logic [31:0] input_weightSeq;
    logic [31:0] decayed_potentialSeq;
    logic [31:0] final_potentialIn;
    logic        spikeIn;

    modport master (
        output input_weightSeq,
        output decayed_potentialSeq,
        input  final_potentialIn,
        input  spikeIn
    );

    modport slave (
        input  input_weightSeq,
        input  decayed_potentialSeq,
        output final_potentialIn,
        output spikeIn
    );
endinterface

// File: rtl/potential_sequencer.sv
// Walks N_NEURONS neurons once per timestep, presenting decayed potential and pending weight to the
// external adder, then storing the adder's potential/spike result back per neuron.
module potential_sequencer #(
    parameter int N_NEURONS   = 10,
    parameter int IDX_W       = 4,
    parameter int LAT         = 2,
    parameter int DECAY_SHIFT = 1
) (
    input  logic                 CLK_Seq,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 weight_wr_en,
    input  logic [IDX_W-1:0]     weight_wr_idx,
    input  logic [31:0]          weight_wr_data,
    potential_sequencer_if.master adder,
    output logic [N_NEURONS-1:0] spike_vector,
    output logic                 busy,
    output logic                 done,
    input  logic [IDX_W-1:0]     pot_rd_idx,
    output logic [31:0]          pot_rd_data
);
    localparam int          CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [7:0]  DS    = 8'(DECAY_SHIFT);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            pot_q [N_NEURONS];
    logic [31:0]            pot_d [N_NEURONS];
    logic [31:0]            wgt_q [N_NEURONS];
    logic [31:0]            wgt_d [N_NEURONS];
    logic [31:0]            w_op_q, w_op_d;
    logic [31:0]            v_op_q, v_op_d;
    logic [N_NEURONS-1:0]   spike_q, spike_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   hit_q, hit_d;
    logic                   wr_valid;
    logic                   wr_cur;
    logic                   wgt_clr;

    // Exponent-decrement decay; inf/NaN pass through, anything that would underflow flushes to zero.
    function automatic logic [31:0] decay(input logic [31:0] p);
        logic [7:0] e;
        e = p[30:23];
        if (DS == 8'd0) begin
            decay = p;
        end else if (e == 8'd255) begin
            decay = p;
        end else if (e <= DS) begin
            decay = 32'h0000_0000;
        end else begin
            decay = {p[31], e - DS, p[22:0]};
        end
    endfunction

    assign wr_valid = weight_wr_en && ({1'b0, weight_wr_idx} < (IDX_W+1)'(N_NEURONS));
    assign wr_cur   = wr_valid && (weight_wr_idx == idx_q);
    // A weight written while its neuron is in flight is kept for the next timestep, not cleared.
    assign wgt_clr  = (state_q == S_CAPTURE) && !hit_q;

    // Next-state, operand and storage update logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pot_d   = pot_q;
        w_op_d  = w_op_q;
        v_op_d  = v_op_q;
        spike_d = spike_q;
        hit_d   = hit_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    idx_d   = '0;
                    spike_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_op_d  = wgt_q[idx_q];
                v_op_d  = decay(pot_q[idx_q]);
                cnt_d   = '0;
                hit_d   = wr_cur;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                hit_d = hit_q | wr_cur;
                if (cnt_q == CNT_W'(LAT - 1)) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                pot_d[idx_q]   = adder.final_potentialIn;
                spike_d[idx_q] = adder.spikeIn;
                if (idx_q == IDX_W'(N_NEURONS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                w_op_d  = 32'h0000_0000;
                v_op_d  = 32'h0000_0000;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        for (int i = 0; i < N_NEURONS; i++) begin
            if (wr_valid && (weight_wr_idx == IDX_W'(i))) begin
                wgt_d[i] = weight_wr_data;
            end else if (wgt_clr && (idx_q == IDX_W'(i))) begin
                wgt_d[i] = 32'h0000_0000;
            end else begin
                wgt_d[i] = wgt_q[i];
            end
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge CLK_Seq) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            pot_q   <= '{default: 32'h0000_0000};
            wgt_q   <= '{default: 32'h0000_0000};
            w_op_q  <= 32'h0000_0000;
            v_op_q  <= 32'h0000_0000;
            spike_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pot_q   <= pot_d;
            wgt_q   <= wgt_d;
            w_op_q  <= w_op_d;
            v_op_q  <= v_op_d;
            spike_q <= spike_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
        end
    end

    // Combinational potential read port.
    always_comb begin
        if ({1'b0, pot_rd_idx} < (IDX_W+1)'(N_NEURONS)) begin
            pot_rd_data = pot_q[pot_rd_idx];
        end else begin
            pot_rd_data = 32'h0000_0000;
        end
    end

    assign adder.input_weightSeq      = w_op_q;
    assign adder.decayed_potentialSeq = v_op_q;
    assign spike_vector               = spike_q;
    assign busy                       = busy_q;
    assign done                       = done_q;
endmodule
